ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, debug wait cycles (legal 1..7) before debug overrides CPU priority.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_req / cpu_we / cpu_lock  input  1 each  CPU access request, write enable, hold-bus for read-modify-write.
REQ-005 cpu_addr  input  7; cpu_wdata  input  8  CPU address and write data.
REQ-006 cpu_gnt  output  1; cpu_rvalid  output  1; cpu_rdata  output  8  CPU grant, read-data valid, read data.
REQ-007 dbg_req / dbg_we  input  1 each; dbg_addr  input  7; dbg_wdata  input  8  debug-port request fields.
REQ-008 dbg_gnt  output  1; dbg_rvalid  output  1; dbg_rdata  output  8  debug grant, read valid, read data.
REQ-009 ram_en  output  1; ram_addr  output  7; ram_data  output  8; ram_q  input  8  single-port 128x8 RAM port.

Function
REQ-010 Grants are combinational from the current requests and state; at most one of cpu_gnt or dbg_gnt is high in any cycle.
REQ-011 A granted request completes in that cycle; ram_addr and ram_data carry the winner's address and write data, and ram_en equals the winner's we.
REQ-012 With no grant: ram_en=0, ram_addr=0, ram_data=0.
REQ-013 A granted read asserts the winner's rvalid for exactly the next cycle; the winner's rdata equals ram_q in that cycle and is 0 otherwise.
REQ-014 A granted write produces no rvalid.
REQ-015 FSM states: IDLE and LOCKED.
REQ-016 IDLE -> LOCKED when the CPU is granted with cpu_lock=1.
REQ-017 LOCKED -> IDLE on a CPU grant with cpu_lock=0 (that access completes normally), or in any cycle with cpu_req=0.
REQ-018 In LOCKED, dbg_gnt=0 unconditionally, and cpu_gnt=cpu_req.
REQ-019 In IDLE, the CPU has priority: cpu_gnt=cpu_req and dbg_gnt=dbg_req & !cpu_req, except where REQ-021 applies.
REQ-020 wait_cnt is a 3-bit saturating counter (max 7).
  - Increments each cycle dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt=1 or dbg_req=0.
REQ-021 In IDLE with wait_cnt >= STARVE_LIMIT and dbg_req=1, debug wins: dbg_gnt=1 and cpu_gnt=0.
REQ-022 Requesters hold req, we, addr and wdata stable until granted; the arbiter does not queue requests.
REQ-023 Same-cycle requests to the same address: only the winner accesses the RAM, and the loser retries the following cycle.
REQ-024 Back-to-back grants to the same requester are allowed every cycle; rvalid pipelines one cycle behind each read grant.

Reset
REQ-025 reset_n low forces, asynchronously:
  - state=IDLE and wait_cnt=0.
  - cpu_rvalid=0 and dbg_rvalid=0.
  - All rdata outputs 0; ram_en=0.
REQ-026 A read granted in the cycle reset asserts produces no rvalid after reset releases.
REQ-027 Reset asserted while LOCKED returns the FSM to IDLE, and the lock is discarded.

Configuration
REQ-028 Macro RAM_ARB_STARVE_GUARD_EN.
  - Defined: wait_cnt and REQ-021 are implemented.
  - Undefined: no wait_cnt, strict CPU priority, and STARVE_LIMIT is ignored.

Verification
REQ-029 cpu_req=1 read addr 0x05 (RAM holds 0x3C) with dbg_req=1 -> cpu_gnt=1 and dbg_gnt=0; next cycle cpu_rvalid=1 and cpu_rdata=0x3C.
REQ-030 cpu_req held high, dbg_req=1 write 0xA5 to 0x10, STARVE_LIMIT=4, guard enabled -> dbg_gnt=1 in the 5th cycle, ram_en=1, ram_addr=0x10, ram_data=0xA5; guard disabled -> dbg_gnt never asserts.
REQ-031 CPU read 0x20 with cpu_lock=1, then write 0x7F to 0x20 with cpu_lock=0, debug requesting throughout -> dbg_gnt=0 during both, and dbg_gnt=1 in the following cycle if cpu_req=0.
REQ-032 Guard enabled, LOCKED with wait_cnt=7 -> dbg_gnt stays 0 until the FSM returns to IDLE, then dbg_gnt=1 immediately.
REQ-033 reset_n pulsed low during a granted CPU read -> cpu_rvalid=0 afterwards, FSM IDLE, wait_cnt=0, all outputs 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - CPU/debug arbiter for a single-port 128x8 RAM with CPU bus lock.
// Optional debug starvation guard enabled by defining RAM_ARB_STARVE_GUARD_EN.
module ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic       cpu_lock,
  input  logic [6:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [6:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_gnt,
  output logic       dbg_rvalid,
  output logic [7:0] dbg_rdata,
  output logic       ram_en,
  output logic [6:0] ram_addr,
  output logic [7:0] ram_data,
  input  logic [7:0] ram_q
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t state_q, state_d;
  logic   cpu_rvalid_q, cpu_rvalid_d;
  logic   dbg_rvalid_q, dbg_rvalid_d;
  logic   starve;

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] wait_cnt_q, wait_cnt_d;

  assign starve = dbg_req && (wait_cnt_q >= LIMIT);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dbg_gnt || !dbg_req) begin
      wait_cnt_d = 3'd0;
    end else if (wait_cnt_q != 3'd7) begin
      wait_cnt_d = wait_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= 3'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic [2:0] unused_limit;
  assign unused_limit = 3'(STARVE_LIMIT);
  assign starve       = 1'b0;
`endif

  // Grants are masked while reset is low so the RAM port stays quiet during reset.
  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (starve) begin
            dbg_gnt = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end else begin
            dbg_gnt = dbg_req;
          end
          if (cpu_gnt && cpu_lock) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          cpu_gnt = cpu_req;
          if (!cpu_req || !cpu_lock) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_addr = 7'd0;
    ram_data = 8'd0;
    if (cpu_gnt) begin
      ram_en   = cpu_we;
      ram_addr = cpu_addr;
      ram_data = cpu_wdata;
    end else if (dbg_gnt) begin
      ram_en   = dbg_we;
      ram_addr = dbg_addr;
      ram_data = dbg_wdata;
    end
  end

  assign cpu_rvalid_d = cpu_gnt && !cpu_we;
  assign dbg_rvalid_d = dbg_gnt && !dbg_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? ram_q : 8'd0;
  assign dbg_rdata  = dbg_rvalid_q ? ram_q : 8'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed vector bench for ram_arbiter.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_req, cpu_we, cpu_lock;
  logic [6:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       dbg_req, dbg_we;
  logic [6:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_rdata;
  logic       ram_en;
  logic [6:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] ram_q;

  int total = 0;
  int bad   = 0;

  ram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cpu_req, cpu_we, cpu_lock;
    logic [6:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       dbg_req, dbg_we;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic [7:0] ram_q;
    logic       e_cg, e_dg, e_en;
    logic [6:0] e_addr;
    logic [7:0] e_data;
    logic       e_crv;
    logic [7:0] e_crd;
    logic       e_drv;
    logic [7:0] e_drd;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [35:0] outs();
    return {cpu_gnt, dbg_gnt, ram_en, ram_addr, ram_data,
            cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic lock,
                         input logic [6:0] addr, input logic [7:0] wdata);
    cpu_req = req; cpu_we = we; cpu_lock = lock; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dbg(input logic req, input logic we,
                         input logic [6:0] addr, input logic [7:0] wdata);
    dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    set_cpu(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    set_dbg(1'b0, 1'b0, 7'h00, 8'h00);
    ram_q = 8'h00;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    set_cpu(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    set_dbg(1'b0, 1'b0, 7'h00, 8'h00);
    ram_q = 8'hC7;
    @(negedge clk);
    check("reset_state", outs(), 36'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // fields: cpu req/we/lock/addr/wdata, dbg req/we/addr/wdata, ram_q, then expected outputs
    vecs[0]  = '{1'b0,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,7'h00,8'h00, 8'h55, 1'b0,1'b0,1'b0,7'h00,8'h00, 1'b0,8'h00,1'b0,8'h00};
    vecs[1]  = '{1'b1,1'b0,1'b0,7'h05,8'h00, 1'b1,1'b0,7'h05,8'h00, 8'h00, 1'b1,1'b0,1'b0,7'h05,8'h00, 1'b0,8'h00,1'b0,8'h00};
    vecs[2]  = '{1'b0,1'b0,1'b0,7'h00,8'h00, 1'b1,1'b0,7'h05,8'h00, 8'h3C, 1'b0,1'b1,1'b0,7'h05,8'h00, 1'b1,8'h3C,1'b0,8'h00};
    vecs[3]  = '{1'b0,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,7'h00,8'h00, 8'h99, 1'b0,1'b0,1'b0,7'h00,8'h00, 1'b0,8'h00,1'b1,8'h99};
    vecs[4]  = '{1'b1,1'b1,1'b0,7'h12,8'h34, 1'b0,1'b0,7'h00,8'h00, 8'h77, 1'b1,1'b0,1'b1,7'h12,8'h34, 1'b0,8'h00,1'b0,8'h00};
    vecs[5]  = '{1'b0,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,7'h00,8'h00, 8'h77, 1'b0,1'b0,1'b0,7'h00,8'h00, 1'b0,8'h00,1'b0,8'h00};
    vecs[6]  = '{1'b0,1'b0,1'b0,7'h00,8'h00, 1'b1,1'b1,7'h40,8'hC3, 8'h00, 1'b0,1'b1,1'b1,7'h40,8'hC3, 1'b0,8'h00,1'b0,8'h00};
    vecs[7]  = '{1'b1,1'b0,1'b0,7'h01,8'h00, 1'b0,1'b0,7'h00,8'h00, 8'h00, 1'b1,1'b0,1'b0,7'h01,8'h00, 1'b0,8'h00,1'b0,8'h00};
    vecs[8]  = '{1'b1,1'b0,1'b0,7'h02,8'h00, 1'b0,1'b0,7'h00,8'h00, 8'h11, 1'b1,1'b0,1'b0,7'h02,8'h00, 1'b1,8'h11,1'b0,8'h00};
    vecs[9]  = '{1'b0,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,7'h00,8'h00, 8'h22, 1'b0,1'b0,1'b0,7'h00,8'h00, 1'b1,8'h22,1'b0,8'h00};
    vecs[10] = '{1'b1,1'b1,1'b0,7'h7F,8'hAA, 1'b1,1'b0,7'h7F,8'h5A, 8'h00, 1'b1,1'b0,1'b1,7'h7F,8'hAA, 1'b0,8'h00,1'b0,8'h00};
    vecs[11] = '{1'b0,1'b0,1'b0,7'h00,8'h00, 1'b1,1'b0,7'h7F,8'h5A, 8'h00, 1'b0,1'b1,1'b0,7'h7F,8'h5A, 1'b0,8'h00,1'b0,8'h00};
    vecs[12] = '{1'b0,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,7'h00,8'h00, 8'hE1, 1'b0,1'b0,1'b0,7'h00,8'h00, 1'b0,8'h00,1'b1,8'hE1};

    for (int i = 0; i < 13; i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      set_cpu(vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_lock, vecs[i].cpu_addr, vecs[i].cpu_wdata);
      set_dbg(vecs[i].dbg_req, vecs[i].dbg_we, vecs[i].dbg_addr, vecs[i].dbg_wdata);
      ram_q = vecs[i].ram_q;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].e_cg, vecs[i].e_dg, vecs[i].e_en, vecs[i].e_addr, vecs[i].e_data,
             vecs[i].e_crv, vecs[i].e_crd, vecs[i].e_drv, vecs[i].e_drd});
    end

    // Debug starvation with CPU requesting every cycle
    do_reset();
    begin
      logic dbg_done;
      logic exp_dg;
      dbg_done = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        if (i != 1) begin
          @(posedge clk); #1;
        end
        set_cpu(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
        set_dbg(!dbg_done, 1'b1, 7'h10, 8'hA5);
`ifdef RAM_ARB_STARVE_GUARD_EN
        exp_dg = (i == 5);
`else
        exp_dg = 1'b0;
`endif
        @(negedge clk);
        check($sformatf("starve_gnt_c%0d", i), {34'h0, cpu_gnt, dbg_gnt}, {34'h0, !exp_dg, exp_dg});
        if (exp_dg) begin
          check("starve_ram", {20'h0, ram_en, ram_addr, ram_data}, {20'h0, 1'b1, 7'h10, 8'hA5});
          dbg_done = 1'b1;
        end
      end
    end

    // Locked read-modify-write blocks debug
    do_reset();
    set_cpu(1'b1, 1'b0, 1'b1, 7'h20, 8'h00);
    set_dbg(1'b1, 1'b0, 7'h33, 8'h00);
    @(negedge clk);
    check("lock_rd", {34'h0, cpu_gnt, dbg_gnt}, {34'h0, 1'b1, 1'b0});
    @(posedge clk); #1;
    set_cpu(1'b1, 1'b1, 1'b0, 7'h20, 8'h7F);
    ram_q = 8'h44;
    @(negedge clk);
    check("lock_wr", outs(), {1'b1, 1'b0, 1'b1, 7'h20, 8'h7F, 1'b1, 8'h44, 1'b0, 8'h00});
    @(posedge clk); #1;
    set_cpu(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    ram_q = 8'h00;
    @(negedge clk);
    check("unlock_dbg", outs(), {1'b0, 1'b1, 1'b0, 7'h33, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00});
    @(posedge clk); #1;
    set_dbg(1'b0, 1'b0, 7'h00, 8'h00);

    // Long lock saturates the wait counter; debug only wins once back in IDLE
    @(posedge clk); #1;
    set_dbg(1'b1, 1'b0, 7'h34, 8'h00);
    for (int i = 0; i < 9; i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      set_cpu(1'b1, 1'b0, 1'b1, 7'h21, 8'h00);
      @(negedge clk);
      check($sformatf("long_lock_c%0d", i), {34'h0, cpu_gnt, dbg_gnt}, {34'h0, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    set_cpu(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    @(negedge clk);
    check("lock_release", {34'h0, cpu_gnt, dbg_gnt}, {34'h0, 1'b0, 1'b0});
    @(posedge clk); #1;
    set_cpu(1'b1, 1'b0, 1'b0, 7'h22, 8'h00);
    @(negedge clk);
`ifdef RAM_ARB_STARVE_GUARD_EN
    check("post_lock", {34'h0, cpu_gnt, dbg_gnt}, {34'h0, 1'b0, 1'b1});
`else
    check("post_lock", {34'h0, cpu_gnt, dbg_gnt}, {34'h0, 1'b1, 1'b0});
`endif

    // Reset pulse during a granted locked CPU read
    do_reset();
    set_cpu(1'b1, 1'b0, 1'b1, 7'h08, 8'h00);
    ram_q = 8'hFF;
    @(negedge clk);
    check("pre_reset_gnt", {34'h0, cpu_gnt, dbg_gnt}, {34'h0, 1'b1, 1'b0});
    #1;
    reset_n = 1'b0;
    #1;
    check("in_reset", outs(), 36'h0);
    @(posedge clk); #1;
    set_cpu(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    @(negedge clk);
    check("held_reset", outs(), 36'h0);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    set_dbg(1'b1, 1'b0, 7'h09, 8'h00);
    @(negedge clk);
    check("after_reset", outs(), {1'b0, 1'b1, 1'b0, 7'h09, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
